// File: rtl/shift_sequencer_if.sv
// shift_sequencer_if: request (in_*) and result (out_*) handshakes plus the busy
// flag for the multi-cycle 32-bit shift sequencer.
// master = ALU issue / writeback side, slave = the sequencer.
interface shift_sequencer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        busy;

    modport master (
        output in_valid, in_data, in_shamt, in_op, out_ready,
        input  in_ready, out_valid, out_data, busy
    );

    modport slave (
        input  in_valid, in_data, in_shamt, in_op, out_ready,
        output in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shifter (sll/srl/sra).
// It applies the power-of-two stages 16, 8, 4, 2, 1 one per clock, MSB stage first.
// Optional macro SHIFT_SKIP_ZERO_EN: RUN visits only the stages whose shamt bit is
// set, and a zero shift (or op 11) goes straight to DONE. Results are identical in
// both builds; only the latency changes.
//
// state | meaning
// IDLE  | in_ready high, waiting for a request
// RUN   | applying stage k (k = 4..0 -> shift by 16/8/4/2/1)
// DONE  | result held on out_data with out_valid high, until out_ready
module shift_sequencer (
    input logic             clock,
    input logic             reset,
    shift_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  k_q, k_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  shamt_q, shamt_d;
    logic [1:0]  op_q, op_d;
    logic        sign_q, sign_d;
    logic [31:0] out_data_q, out_data_d;
    logic [31:0] stage_val;

    // Shift by 2**k. sra fills with the sign captured at accept; op 11 passes through.
    function automatic logic [31:0] stage_shift(input logic [31:0] w, input logic [2:0] k,
                                                input logic [1:0] op, input logic sign);
        logic [4:0]  amt;
        logic [31:0] fill;
        logic [31:0] res;
        amt  = 5'd1 << k;
        fill = ~(32'hFFFF_FFFF >> amt);
        case (op)
            2'b00:   res = w << amt;
            2'b01:   res = w >> amt;
            2'b10:   res = (w >> amt) | (sign ? fill : 32'h0);
            default: res = w;
        endcase
        return res;
    endfunction

`ifdef SHIFT_SKIP_ZERO_EN
    // Index of the highest set bit; only called with a nonzero argument.
    function automatic logic [2:0] top_bit(input logic [4:0] bits);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 5; i++) begin
            if (bits[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    logic [4:0] lower_bits;
`endif

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            k_q        <= 3'd4;
            work_q     <= 32'h0;
            shamt_q    <= 5'd0;
            op_q       <= 2'b00;
            sign_q     <= 1'b0;
            out_data_q <= 32'h0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            work_q     <= work_d;
            shamt_q    <= shamt_d;
            op_q       <= op_d;
            sign_q     <= sign_d;
            out_data_q <= out_data_d;
        end
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        work_d     = work_q;
        shamt_d    = shamt_q;
        op_d       = op_q;
        sign_d     = sign_q;
        out_data_d = out_data_q;
        stage_val  = stage_shift(work_q, k_q, op_q, sign_q);
`ifdef SHIFT_SKIP_ZERO_EN
        lower_bits = shamt_q & ((5'd1 << k_q) - 5'd1);
`endif
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    work_d  = bus.in_data;
                    shamt_d = bus.in_shamt;
                    op_d    = bus.in_op;
                    sign_d  = bus.in_data[31];
`ifdef SHIFT_SKIP_ZERO_EN
                    if (bus.in_shamt == 5'd0 || bus.in_op == 2'b11) begin
                        state_d    = DONE;
                        out_data_d = bus.in_data;
                    end else begin
                        state_d = RUN;
                        k_d     = top_bit(bus.in_shamt);
                    end
`else
                    state_d = RUN;
                    k_d     = 3'd4;
`endif
                end
            end
            RUN: begin
                if (shamt_q[k_q]) work_d = stage_val;
`ifdef SHIFT_SKIP_ZERO_EN
                if (lower_bits != 5'd0) begin
                    k_d = top_bit(lower_bits);
                end else begin
                    state_d    = DONE;
                    k_d        = 3'd4;
                    out_data_d = shamt_q[k_q] ? stage_val : work_q;
                end
`else
                if (k_q == 3'd0) begin
                    state_d    = DONE;
                    k_d        = 3'd4;
                    out_data_d = shamt_q[k_q] ? stage_val : work_q;
                end else begin
                    k_d = k_q - 3'd1;
                end
`endif
            end
            DONE: begin
                if (bus.out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state; out_data comes from a register.
    always_comb begin
        bus.in_ready  = (state_q == IDLE);
        bus.out_valid = (state_q == DONE);
        bus.busy      = (state_q != IDLE);
        bus.out_data  = out_data_q;
    end
endmodule

// File: tb/tb_shift_sequencer.sv
// tb_shift_sequencer: self-checking bench for shift_sequencer. The expected result
// comes from plain shift operators and the expected latency from the shift amount.
// Compile with +define+SHIFT_SKIP_ZERO_EN to check the skip-zero timing.
module tb_shift_sequencer;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    shift_sequencer_if bus();

    shift_sequencer dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    function automatic logic [31:0] model_res(input logic [31:0] d, input logic [4:0] s,
                                              input logic [1:0] op);
        logic [31:0] r;
        case (op)
            2'b00:   r = d << s;
            2'b01:   r = d >> s;
            2'b10:   r = $unsigned($signed(d) >>> s);
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic int model_lat(input logic [4:0] s, input logic [1:0] op);
`ifdef SHIFT_SKIP_ZERO_EN
        if (s == 5'd0 || op == 2'b11) return 0;
        return $countones(s);
`else
        return 5;
`endif
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++;
            $display("FAIL %s: in_ready timeout got=%0b required=1", name, bus.in_ready);
        end
    endtask

    // Accept edge, then count cycles to out_valid, check data, then hold for stall cycles.
    task automatic run_op(input string name, input logic [31:0] d, input logic [4:0] s,
                          input logic [1:0] op, input int stall);
        logic [31:0] exp_d;
        int          n;
        exp_d = model_res(d, s, op);
        wait_ready(name);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_shamt = s;
        bus.in_op    = op;
        tick();
        bus.in_valid = 1'b0;
        bus.in_data  = $urandom;
        bus.in_shamt = 5'($urandom);
        bus.in_op    = 2'($urandom);
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL %s busy: got=%b required=1", name, bus.busy);
        end
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n != model_lat(s, op)) begin
            errors++;
            $display("FAIL %s latency: got=%0d required=%0d", name, n, model_lat(s, op));
        end
        checks++;
        if (bus.out_data !== exp_d) begin
            errors++;
            $display("FAIL %s data: got=%h required=%h", name, bus.out_data, exp_d);
        end
        for (int i = 0; i < stall; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== exp_d) begin
                errors++;
                $display("FAIL %s hold: got valid=%b data=%h required valid=1 data=%h",
                         name, bus.out_valid, bus.out_data, exp_d);
            end
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s release: got valid=%b in_ready=%b required 0/1",
                     name, bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL reset: got rdy=%b vld=%b busy=%b data=%h required 1/0/0/00000000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
    endtask

    task automatic test_ready_timing();
        int          low;
        logic [31:0] got;
        got = 32'h0;
        wait_ready("ready_timing");
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_data   = 32'h0000_00FF;
        bus.in_shamt  = 5'd8;
        bus.in_op     = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        low = 0;
        while (!bus.in_ready && low < 20) begin
            if (bus.out_valid) got = bus.out_data;
            low++;
            tick();
        end
        bus.out_ready = 1'b0;
        checks++;
        if (low != model_lat(5'd8, 2'b00) + 1) begin
            errors++;
            $display("FAIL ready_timing low cycles: got=%0d required=%0d", low,
                     model_lat(5'd8, 2'b00) + 1);
        end
        checks++;
        if (got !== 32'h0000_FF00) begin
            errors++;
            $display("FAIL ready_timing data: got=%h required=0000ff00", got);
        end
    endtask

    task automatic test_directed();
        run_op("sll_ff_8",  32'h0000_00FF, 5'd8,  2'b00, 0);
        run_op("sra_min",   32'h8000_0000, 5'd31, 2'b10, 0);
        run_op("srl_min",   32'h8000_0000, 5'd31, 2'b01, 0);
        run_op("sra_pos",   32'h7FFF_FFF0, 5'd4,  2'b10, 0);
        run_op("shamt0",    32'hDEAD_BEEF, 5'd0,  2'b01, 0);
        run_op("op11",      32'h1234_5678, 5'd5,  2'b11, 0);
        run_op("sll_31",    32'h0000_0001, 5'd31, 2'b00, 0);
        run_op("skip_17",   32'hA5A5_0F0F, 5'd17, 2'b10, 0);
    endtask

    task automatic test_backpressure();
        logic [31:0] a_exp;
        logic [31:0] b_exp;
        int          n;
        a_exp = model_res(32'hF0F0_1234, 5'd3, 2'b10);
        b_exp = model_res(32'h0000_0F00, 5'd6, 2'b01);
        wait_ready("bp");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hF0F0_1234;
        bus.in_shamt = 5'd3;
        bus.in_op    = 2'b10;
        tick();
        bus.in_data  = 32'h0000_0F00;
        bus.in_shamt = 5'd6;
        bus.in_op    = 2'b01;
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_data !== a_exp || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL bp hold %0d: got vld=%b data=%h rdy=%b required 1/%h/0",
                         i, bus.out_valid, bus.out_data, bus.in_ready, a_exp);
            end
            tick();
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp idle: got rdy=%b vld=%b required 1/0", bus.in_ready, bus.out_valid);
        end
        tick();
        bus.in_valid = 1'b0;
        checks++;
        if (bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL bp accept: got busy=%b required=1", bus.busy);
        end
        n = 0;
        while (!bus.out_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.out_data !== b_exp || n != model_lat(5'd6, 2'b01)) begin
            errors++;
            $display("FAIL bp second: got data=%h lat=%0d required %h/%0d",
                     bus.out_data, n, b_exp, model_lat(5'd6, 2'b01));
        end
        bus.out_ready = 1'b1;
        tick();
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset_abort();
        wait_ready("abort");
        bus.in_valid = 1'b1;
        bus.in_data  = 32'hCAFE_F00D;
        bus.in_shamt = 5'd31;
        bus.in_op    = 2'b00;
        tick();
        bus.in_valid = 1'b0;
        tick();
        tick();
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.busy !== 1'b0 ||
            bus.out_data !== 32'h0) begin
            errors++;
            $display("FAIL abort: got rdy=%b vld=%b busy=%b data=%h required 1/0/0/00000000",
                     bus.in_ready, bus.out_valid, bus.busy, bus.out_data);
        end
        @(negedge clock);
        reset = 1'b1;
        tick();
        run_op("after_abort", 32'h0000_0001, 5'd1, 2'b00, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 30; i++) begin
            run_op("random", $urandom, 5'($urandom), 2'($urandom), int'($urandom_range(0, 3)));
        end
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = 32'h0;
        bus.in_shamt  = 5'd0;
        bus.in_op     = 2'b00;
        bus.out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clock);
        reset = 1'b1;
        tick();
        test_reset();
        test_ready_timing();
        test_directed();
        test_backpressure();
        test_reset_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/shift_sequencer.md
# shift_sequencer

Multi-cycle 32-bit shift unit controller for the processor datapath. It accepts one operand, shift amount and shift type over a valid/ready handshake. It then drives the fixed power-of-two shift stages (16, 8, 4, 2, 1) one per clock, MSB stage first, and holds the result on a valid/ready output until the consumer takes it. It sits between the ALU issue logic and the writeback mux, replacing a single-cycle barrel shifter where timing requires it.

## Interface
- WIDTH, 32, datapath width; only 32 is supported (five stages, 5-bit shift amount).
- clock  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid  input  1  request present
- in_ready  output  1  sequencer can accept a request (IDLE only)
- in_data  input  32  operand
- in_shamt  input  5  shift amount 0–31
- in_op  input  2  00 = sll, 01 = srl, 10 = sra, 11 = reserved
- out_valid  output  1  result available
- out_ready  input  1  consumer takes the result
- out_data  output  32  result
- busy  output  1  high in RUN or DONE

## Operation
- States: IDLE, RUN, DONE. 3-bit stage index `k` selects the stage; `k` = 4..0 maps to 16/8/4/2/1.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch in_data into the working register, and latch shamt, op and sign = in_data[31].
  - Load the first stage to apply and go to RUN.
- RUN, each cycle:
  - If shamt[k] = 1, the working register takes the stage-k shifted value; otherwise it is unchanged.
  - When `k` = 0 (last stage), go to DONE.
- Stage rules:
  - sll shifts in zeros at the LSB.
  - srl shifts in zeros at the MSB.
  - sra shifts in the latched sign bit at the MSB.
- op = 11 applies no shift in any stage; the result equals the operand. Latency is the same as for a real op.
- DONE:
  - out_valid = 1; out_data = working register.
  - On out_ready, go to IDLE.
  - While out_ready = 0, out_data and out_valid stay constant.
- in_ready is 0 outside IDLE. A request arriving while out_valid && out_ready are both high is not accepted that cycle; it is accepted the next cycle.
- Inputs are sampled only on the accept edge; later changes to in_* have no effect.

## Timing
- Reset values: state IDLE, in_ready = 1, out_valid = 0, busy = 0, out_data = 0x00000000, `k` = 4.
- Reset mid-RUN or mid-DONE aborts the operation immediately (asynchronous). No result is produced.
- Default latency is fixed:
  - Accept at edge E.
  - Stages are applied at edges E+1 … E+5.
  - out_valid is high from edge E+5.
- Earliest consecutive accept is edge E+7 if out_ready is held high. Throughput is one operation per 7 cycles.
- out_data is registered and changes only on entry to DONE or on reset.

## Configuration
- SHIFT_SKIP_ZERO_EN
  - Defined: RUN visits only stages whose shamt bit is 1, so latency L = popcount(shamt) and out_valid rises at edge E+L.
  - shamt = 0, or op = 11: go from IDLE straight to DONE at edge E, with out_data = operand.
  - Not defined: the fixed 5-cycle latency above for every shamt.
  - Results are identical in both builds; only timing differs.

## Test plan
- sll, in_data 0x000000FF, shamt 8, out_ready = 1 → out_data 0x0000FF00; out_valid exactly 5 cycles after accept; in_ready low for 6 cycles.
- sra, in_data 0x80000000, shamt 31 → 0xFFFFFFFF. srl with the same inputs → 0x00000001. sra, 0x7FFFFFF0, shamt 4 → 0x07FFFFFF.
- Backpressure: complete any op with out_ready = 0 for 4 cycles → out_valid and out_data stable; in_valid held high is not accepted. Raise out_ready → IDLE next edge, accept the edge after.
- Reset asserted two cycles after accept → outputs return to reset values asynchronously. After release, a new sll 0x1, shamt 1 → 0x00000002.
- Boundaries: shamt 0 → result equals operand; op 11, 0x12345678, shamt 5 → 0x12345678; shamt 31 sll of 0x00000001 → 0x80000000.
- With SHIFT_SKIP_ZERO_EN: shamt 0 → out_valid at the accept edge; shamt 0b10001 → out_valid 2 cycles after accept; shamt 31 → 5 cycles.
